// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the timer alarm stage: state encoding and its width.
package timer_alarm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_alarm_unit_if.sv
// Control/status bundle between a timer-alarm controller (master) and the unit (slave).
interface timer_alarm_unit_if #(
    parameter int CNT_W = 8
);
    // start/stop/irq_ack are single-cycle requests with no ready: the unit
    // accepts them on the edge they are seen (stop beats start, start needs
    // compare_val != 0). alarm is a one-cycle pulse; irq holds until acked.
    logic             tick_in;
    logic             start;
    logic             stop;
    logic             mode_periodic;
    logic [CNT_W-1:0] compare_val;
    logic             irq_ack;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             alarm;
    logic             irq;
    logic             done;

    modport master (
        output tick_in, start, stop, mode_periodic, compare_val, irq_ack,
        input  count, busy, alarm, irq, done
    );

    modport slave (
        input  tick_in, start, stop, mode_periodic, compare_val, irq_ack,
        output count, busy, alarm, irq, done
    );

endinterface

// File: rtl/timer_alarm_unit_rise_edge_detect.sv
// Rising-edge detector for a same-clock-domain level; a held-high level yields one pulse.
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise_out
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_in;
        end
    end

    assign rise_out = sig_in & ~sig_q;

endmodule

// File: rtl/timer_alarm_unit.sv
// Counts rising edges of the timer output and raises alarm/irq when the
// programmed count is reached; one-shot or auto-reload operation.
module timer_alarm_unit
    import timer_alarm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    timer_alarm_unit_if.slave  bus,
    output logic [STATE_W-1:0] dbg_state
);

    state_t           state;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] cmp_q;
    logic             mode_q;
    logic             alarm_q;
    logic             irq_q;
    logic             tick_rise;
    logic             start_ok;
    logic             match;

    rise_edge_detect u_tick_edge (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (bus.tick_in),
        .rise_out (tick_rise)
    );

    assign start_ok = bus.start && (bus.compare_val != '0);
    // cmp_q is never zero while in RUN, so cmp_q-1 cannot wrap there.
    assign match    = tick_rise && (count_q == cmp_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count_q <= '0;
            cmp_q   <= '0;
            mode_q  <= 1'b0;
            alarm_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            alarm_q <= 1'b0;
            if (bus.irq_ack) begin
                irq_q <= 1'b0;
            end

            if (bus.stop) begin
                state <= ST_IDLE;
            end else if (start_ok) begin
                cmp_q   <= bus.compare_val;
                mode_q  <= bus.mode_periodic;
                count_q <= '0;
                state   <= ST_RUN;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_DONE: ;
                    ST_RUN: begin
                        if (match) begin
                            // Assigned after the ack clear so a same-cycle match keeps irq set.
                            alarm_q <= 1'b1;
                            irq_q   <= 1'b1;
                            if (mode_q) begin
                                count_q <= '0;
                            end else begin
                                count_q <= cmp_q;
                                state   <= ST_DONE;
                            end
                        end else if (tick_rise) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.count = count_q;
    assign bus.alarm = alarm_q;
    assign bus.irq   = irq_q;
    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_timer_alarm_unit.sv
// Directed bench for timer_alarm_unit with hand-computed expectations.
module tb_timer_alarm_unit;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;

  logic [7:0] exp_q[$];

  timer_alarm_unit_if #(.CNT_W(8)) bus ();

  timer_alarm_unit #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the edge, outputs read there too
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.tick_in = 1'b1;
    cyc(1);
    bus.tick_in = 1'b0;
    cyc(1);
  endtask

  task automatic do_start(input logic [7:0] cv, input logic periodic);
    bus.start         = 1'b1;
    bus.compare_val   = cv;
    bus.mode_periodic = periodic;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst               = 1'b1;
    bus.tick_in       = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.mode_periodic = 1'b0;
    bus.compare_val   = 8'd0;
    bus.irq_ack       = 1'b0;
    #1;

    // 1. reset with tick toggling
    repeat (2) begin
      bus.tick_in = ~bus.tick_in;
      cyc(1);
    end
    check_vec("rst_count", bus.count, 0);
    check_vec("rst_alarm", bus.alarm, 0);
    check_vec("rst_irq",   bus.irq,   0);
    check_vec("rst_busy",  bus.busy,  0);
    check_vec("rst_done",  bus.done,  0);
    check_vec("rst_state", dbg_state, 0);
    rst = 1'b0;
    bus.tick_in = 1'b0;
    cyc(1);

    // 2. periodic, compare 3, tick every 4 cycles
    do_start(8'd3, 1'b1);
    check_vec("p_busy0",  bus.busy,  1);
    check_vec("p_count0", bus.count, 0);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'((i + 1) % 3));
    for (int i = 0; i < 9; i++) begin
      bus.tick_in = 1'b1;
      cyc(1);
      check_vec("p_count", bus.count, int'(exp_q.pop_front()));
      check_vec("p_alarm", bus.alarm, (i % 3 == 2) ? 1 : 0);
      check_vec("p_busy",  bus.busy,  1);
      bus.tick_in = 1'b0;
      cyc(1);
      check_vec("p_alarm_low", bus.alarm, 0);
      cyc(2);
    end
    check_vec("p_irq", bus.irq, 1);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    check_vec("p_irq_clr", bus.irq, 0);

    // 3. one-shot with a level tick
    do_start(8'd2, 1'b0);
    bus.tick_in = 1'b1;
    cyc(3);
    check_vec("o_level_count", bus.count, 1);
    check_vec("o_level_alarm", bus.alarm, 0);
    bus.tick_in = 1'b0;
    cyc(1);
    bus.tick_in = 1'b1;
    cyc(1);
    check_vec("o_alarm", bus.alarm, 1);
    check_vec("o_count", bus.count, 2);
    check_vec("o_done",  bus.done,  1);
    check_vec("o_busy",  bus.busy,  0);
    check_vec("o_state", dbg_state, 2);
    check_vec("o_irq",   bus.irq,   1);
    bus.tick_in = 1'b0;
    cyc(1);
    check_vec("o_alarm_once", bus.alarm, 0);
    pulse();
    check_vec("o_done_hold", bus.count, 2);
    check_vec("o_done_alarm", bus.alarm, 0);

    // 4. irq handshake
    cyc(10);
    check_vec("i_sticky", bus.irq, 1);
    do_start(8'd2, 1'b1);
    pulse();
    check_vec("i_pre_count", bus.count, 1);
    bus.tick_in = 1'b1;
    bus.irq_ack = 1'b1;
    cyc(1);
    check_vec("i_set_wins_alarm", bus.alarm, 1);
    check_vec("i_set_wins_irq",   bus.irq,   1);
    check_vec("i_reload_count",   bus.count, 0);
    bus.tick_in = 1'b0;
    bus.irq_ack = 1'b0;
    cyc(1);
    check_vec("i_still_set", bus.irq, 1);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    check_vec("i_ack_clr", bus.irq, 0);
    bus.irq_ack = 1'b1;
    cyc(1);
    bus.irq_ack = 1'b0;
    check_vec("i_ack_idle", bus.irq, 0);

    // 5. control collisions
    pulse();
    check_vec("c_pre_count", bus.count, 1);
    bus.start       = 1'b1;
    bus.stop        = 1'b1;
    bus.compare_val = 8'd7;
    cyc(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_vec("c_startstop_busy",  bus.busy,  0);
    check_vec("c_startstop_state", dbg_state, 0);
    check_vec("c_startstop_count", bus.count, 1);
    pulse();
    check_vec("c_idle_count", bus.count, 1);
    do_start(8'd0, 1'b1);
    check_vec("c_zero_busy",  bus.busy,  0);
    check_vec("c_zero_count", bus.count, 1);
    do_start(8'd10, 1'b1);
    repeat (5) pulse();
    check_vec("c_mid_count", bus.count, 5);
    do_start(8'd0, 1'b0);
    check_vec("c_zero_run_busy",  bus.busy,  1);
    check_vec("c_zero_run_count", bus.count, 5);
    bus.tick_in = 1'b1;
    do_start(8'd6, 1'b1);
    check_vec("c_restart_count", bus.count, 0);
    bus.tick_in = 1'b0;
    cyc(1);
    repeat (5) pulse();
    check_vec("c_new_cmp_count", bus.count, 5);
    check_vec("c_new_cmp_noalarm", bus.alarm, 0);
    bus.tick_in = 1'b1;
    cyc(1);
    check_vec("c_new_cmp_alarm", bus.alarm, 1);
    check_vec("c_new_cmp_wrap",  bus.count, 0);
    bus.tick_in = 1'b0;
    cyc(1);
    pulse();
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    check_vec("c_stop_busy",  bus.busy,  0);
    check_vec("c_stop_count", bus.count, 1);

    // 6. reset mid-operation
    do_start(8'd3, 1'b1);
    pulse();
    pulse();
    check_vec("r_pre_count", bus.count, 2);
    check_vec("r_pre_irq",   bus.irq,   1);
    rst = 1'b1;
    bus.tick_in = 1'b1;
    cyc(1);
    check_vec("r_count", bus.count, 0);
    check_vec("r_alarm", bus.alarm, 0);
    check_vec("r_irq",   bus.irq,   0);
    check_vec("r_busy",  bus.busy,  0);
    check_vec("r_done",  bus.done,  0);
    rst = 1'b0;
    bus.tick_in = 1'b0;
    cyc(1);
    check_vec("r_after_alarm", bus.alarm, 0);
    check_vec("r_after_state", dbg_state, 0);

    // 7. full-scale compare value
    do_start(8'd255, 1'b0);
    repeat (254) pulse();
    check_vec("m_count", bus.count, 254);
    check_vec("m_busy",  bus.busy,  1);
    bus.tick_in = 1'b1;
    cyc(1);
    check_vec("m_alarm", bus.alarm, 1);
    check_vec("m_final", bus.count, 255);
    check_vec("m_done",  bus.done,  1);
    bus.tick_in = 1'b0;
    cyc(1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
